// File: rtl/load_request_sequencer_if.sv
// load_request_sequencer_if: request, memory and writeback/exception signals of the load sequencer
interface load_request_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_base;
  logic [11:0] req_imm;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic        mem_start;
  logic [31:0] mem_address;
  logic [2:0]  mem_mode;
  logic        mem_done;
  logic [31:0] mem_read_data;
  logic        wb_enable;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_address;
  modport master (
    output req_valid, req_base, req_imm, req_funct3, req_rd, mem_done, mem_read_data,
    input  req_ready, mem_start, mem_address, mem_mode, wb_enable, wb_rd, wb_data,
           busy, exc_valid, exc_cause, exc_address
  );
  modport slave (
    input  req_valid, req_base, req_imm, req_funct3, req_rd, mem_done, mem_read_data,
    output req_ready, mem_start, mem_address, mem_mode, wb_enable, wb_rd, wb_data,
           busy, exc_valid, exc_cause, exc_address
  );
endinterface

// File: rtl/load_request_sequencer.sv
// load_request_sequencer: checks and issues one load, waits for memory with timeout, writes back extended data
module load_request_sequencer #(
  parameter int TIMEOUT      = 32,
  parameter int FLUSH_CYCLES = 8
) (
  input logic clk,
  input logic reset,
  load_request_sequencer_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic [2:0] {FLUSH, IDLE, ISSUE, WAIT, WB, EXC} state_t;
  state_t state, state_next;
  logic [FW-1:0] flush_cnt;
  logic [TW-1:0] wait_cnt;
  logic [31:0] ea, ea_q, read_ext, wb_data_q, exc_address_q;
  logic [2:0] mode_q;
  logic [4:0] rd_q;
  logic [1:0] exc_cause_q;
  logic done_prev, accept, illegal, misaligned, complete, timed_out;
  assign ea = bus.req_base + {{20{bus.req_imm[11]}}, bus.req_imm};
  // request decode, done edge detect and load-result extension
  always_comb begin
    accept     = bus.req_valid && state == IDLE;
    illegal    = bus.req_funct3 inside {3'b011, 3'b110, 3'b111};
    misaligned = (bus.req_funct3[1:0] == 2'b01 && ea[0]) || (bus.req_funct3 == 3'b010 && ea[1:0] != 2'b00);
    complete   = bus.mem_done && !done_prev;
    timed_out  = !complete && wait_cnt == TW'(TIMEOUT - 1);
    read_ext   = mode_q[1:0] == 2'b00 ? {{24{~mode_q[2] & bus.mem_read_data[7]}}, bus.mem_read_data[7:0]} :
                 mode_q[1:0] == 2'b01 ? {{16{~mode_q[2] & bus.mem_read_data[15]}}, bus.mem_read_data[15:0]} :
                 bus.mem_read_data;
  end
  // state register; reset always lands in FLUSH so an aborted transfer can drain
  always_ff @(posedge clk)
    state <= reset ? FLUSH : state_next;
  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      FLUSH:   state_next = flush_cnt == '0 ? IDLE : FLUSH;
      IDLE:    state_next = !accept ? IDLE : (illegal || misaligned) ? EXC : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    state_next = complete ? WB : timed_out ? EXC : WAIT;
      WB:      state_next = IDLE;
      EXC:     state_next = IDLE;
      default: state_next = FLUSH;
    endcase
  end
  // counters, latched request and held result/exception registers
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt     <= FW'(FLUSH_CYCLES);
      wait_cnt      <= '0;
      done_prev     <= 1'b0;
      ea_q          <= '0;
      mode_q        <= '0;
      rd_q          <= '0;
      wb_data_q     <= '0;
      exc_cause_q   <= '0;
      exc_address_q <= '0;
    end else begin
      flush_cnt <= (state == FLUSH && flush_cnt != '0) ? flush_cnt - 1'b1 : flush_cnt;
      wait_cnt  <= state == WAIT ? wait_cnt + 1'b1 : '0;
      done_prev <= state == WAIT && bus.mem_done;
      if (accept) begin
        ea_q   <= ea;
        mode_q <= bus.req_funct3;
        rd_q   <= bus.req_rd;
      end
      if (accept && (illegal || misaligned)) begin
        exc_cause_q   <= illegal ? 2'b10 : 2'b01;
        exc_address_q <= ea;
      end
      if (state == WAIT && timed_out) begin
        exc_cause_q   <= 2'b11;
        exc_address_q <= ea_q;
      end
      if (state == WAIT && complete && rd_q != '0)
        wb_data_q <= read_ext;
    end
  end
  // outputs decoded from the state register and held data registers
  always_comb begin
    bus.req_ready   = state == IDLE;
    bus.busy        = state != IDLE;
    bus.mem_start   = state == ISSUE;
    bus.mem_address = ea_q;
    bus.mem_mode    = mode_q;
    bus.wb_enable   = state == WB && rd_q != '0;
    bus.wb_rd       = rd_q;
    bus.wb_data     = wb_data_q;
    bus.exc_valid   = state == EXC;
    bus.exc_cause   = exc_cause_q;
    bus.exc_address = exc_address_q;
  end
endmodule
